// File: rtl/dpram_be_rmw_master_if.sv
// Request, response and RAM-side signals of the byte-enable read-merge-write master.
interface dpram_be_rmw_master_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  localparam int BEW = DW / 8;

  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic [BEW-1:0] req_be;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           wr_ack;
  logic           ram_we;
  logic [AW-1:0]  ram_wr_addr;
  logic [DW-1:0]  ram_wr_data;
  logic [AW-1:0]  ram_rd_addr;
  logic [DW-1:0]  ram_q;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_be, ram_q,
    output req_ready, rsp_valid, rsp_rdata, wr_ack,
           ram_we, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_be, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, wr_ack,
           ram_we, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/dpram_be_rmw_master.sv
// Request master for a DPRAM without byte enables: partial writes become read-merge-write.
// Optional RMW_FWD_EN: forward reads/merges from the last word written (ram_wr_* act as the shadow).
module dpram_be_rmw_lane (
  input  logic       be,
  input  logic [7:0] wr_byte,
  input  logic [7:0] old_byte,
  output logic [7:0] out_byte
);
  assign out_byte = be ? wr_byte : old_byte;
endmodule

module dpram_be_rmw_master #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input logic clk,
  input logic rst_n,
  dpram_be_rmw_master_if.master bus
);
  localparam int BEW = DW / 8;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;
  typedef struct packed {
    logic           we;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
  } req_t;

  state_t         state;
  req_t           lat;
  logic           accept, full_be, null_be, fwd_hit;
  logic [BEW-1:0] m_be;
  logic [DW-1:0]  m_wr, m_old, merged;

  assign bus.req_ready = (state == IDLE);
  assign accept  = bus.req_valid & bus.req_ready;
  assign full_be = &bus.req_be;
  assign null_be = ~|bus.req_be;

`ifdef RMW_FWD_EN
  logic sh_vld;
  assign fwd_hit = sh_vld && (bus.req_addr == bus.ram_wr_addr);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            sh_vld <= 1'b0;
    else if (state == WR)  sh_vld <= 1'b1;
`else
  assign fwd_hit = 1'b0;
`endif

  // In IDLE the merge sees the live request against the shadow; otherwise the latched one against ram_q.
  always_comb begin
    m_be  = lat.be;
    m_wr  = lat.wdata;
    m_old = bus.ram_q;
    if (state == IDLE) begin
      m_be  = bus.req_be;
      m_wr  = bus.req_wdata;
      m_old = bus.ram_wr_data;
    end
  end

  for (genvar i = 0; i < BEW; i++) begin : g_lane
    dpram_be_rmw_lane u_lane (
      .be       (m_be[i]),
      .wr_byte  (m_wr[8*i +: 8]),
      .old_byte (m_old[8*i +: 8]),
      .out_byte (merged[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat             <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.wr_ack      <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_wr_addr <= '0;
      bus.ram_wr_data <= '0;
      bus.ram_rd_addr <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.ram_we    <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          lat             <= '{we: bus.req_we, be: bus.req_be, wdata: bus.req_wdata};
          bus.ram_rd_addr <= bus.req_addr;
          if (!bus.req_we) begin
            if (fwd_hit) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= bus.ram_wr_data;
            end else begin
              state <= RD;
            end
          end else if (null_be) begin
            bus.wr_ack <= 1'b1;
          end else if (full_be || fwd_hit) begin
            bus.ram_we      <= 1'b1;
            bus.wr_ack      <= 1'b1;
            bus.ram_wr_addr <= bus.req_addr;
            bus.ram_wr_data <= merged;
            state           <= WR;
          end else begin
            state <= RD;
          end
        end
        RD:  state <= CAP;
        CAP: begin
          if (lat.we) begin
            bus.ram_we      <= 1'b1;
            bus.wr_ack      <= 1'b1;
            bus.ram_wr_addr <= bus.ram_rd_addr;
            bus.ram_wr_data <= merged;
            state           <= WR;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.ram_q;
            state         <= IDLE;
          end
        end
        WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
